alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU for the CPU datapath, succeeding the fixed 16-bit single-cycle ALU. It keeps opcodes 0–10 with unchanged semantics and adds shift and multiply operations. Operations are issued with a start/done handshake: logical and arithmetic ops complete in one cycle, and multiply runs iteratively over WIDTH cycles. Result and flags are registered and held until the next completed operation.

## Interface
- WIDTH, 16, operand/result width; legal values are 8 to 64.
- SHW, $clog2(WIDTH), number of shift-amount bits taken from b.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  issue request; sampled only when busy=0.
- codop  in  4  operation code; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse; out and flags were updated on this edge.
- out  out  WIDTH  result register.
- neg  out  1  out[WIDTH-1] of the last result.
- zero  out  1  last result equals 0.
- overflow  out  1  overflow of the last result, per opcode rule below.

## Operation
- Operands and codop are latched when start=1 and busy=0. While busy=1, start is ignored and not queued.
- Result rules (all arithmetic unsigned, modulo 2^WIDTH):
  - 0 add: b+a. 9 addi: a+b. For both, overflow = carry-out of the WIDTH-bit add.
  - 1 sub: b−a, overflow = (a>b). 10 subi: a−b, overflow = (a<b).
  - 2 slti: 1 if a>b, else 0. overflow=0.
  - 3/6 and, 4/7 or, 5/8 xor: bitwise operations. overflow=0.
  - 11 shl: a << b[SHW-1:0]. 12 shr: logical a >> b[SHW-1:0]. 14 sra: arithmetic a >>> b[SHW-1:0]. For all shifts, overflow=0.
  - 13 mul: low WIDTH bits of a*b; overflow = (upper WIDTH bits of the 2·WIDTH-bit product ≠ 0).
  - 15: out=0, overflow=0. Still completes with a done pulse.
- neg and zero are computed from the new result and registered on the same edge as out.
- Flags and out change only on a done edge; otherwise all four hold their values.
- State machine:
  - IDLE: start with codop≠13 → compute and register the result, pulse done, stay in IDLE.
  - IDLE: start with codop=13 → latch operands, clear the accumulator, cnt=0, go to MUL, busy=1.
  - MUL: each cycle, if multiplier bit cnt is 1, add (a<<cnt) into a 2·WIDTH-bit accumulator; cnt++. When cnt=WIDTH−1, register the result and flags, pulse done, busy=0, return to IDLE.
- Reset values: state=IDLE, busy=0, done=0, out=0, neg=0, zero=0, overflow=0.
- Reset wins over start on the same edge.
- Reset during MUL aborts the operation: no done pulse, and out keeps no partial result.

## Timing
- Single-cycle op with start at edge k: out, flags and done=1 are visible after edge k. done returns to 0 after edge k+1 unless a new op starts at k+1.
- Back-to-back single-cycle ops can issue every cycle, giving a done pulse each cycle.
- mul with start at edge k:
  - busy=1 after edge k.
  - Bits are processed on edges k+1 through k+WIDTH.
  - done=1 and busy=0 after edge k+WIDTH, so latency is WIDTH cycles.
  - A new start is accepted on edge k+WIDTH+1 at the earliest. start asserted at edge k+WIDTH is ignored, because busy is still 1 when sampled.
- Changes on a, b or codop while busy=1 have no effect on the result.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 → busy=0, done=0, out=0, and all flags 0.
- add, WIDTH=16: a=16'hFFFF, b=16'h0002, codop=0 → out=16'h0001, overflow=1, zero=0, neg=0, done pulse after 1 edge. Then sub with a=5, b=5 → out=0, zero=1, overflow=0.
- Shifts: a=16'h8001, b=4, codop 11/12/14 issued back-to-back → out=16'h0010, then 16'h0800, then 16'hF800. Three consecutive done pulses.
- mul: a=300, b=300, codop=13 → busy for 16 cycles, out=16'h5F90 (90000 mod 65536), overflow=1. A start issued mid-multiply is ignored, verified by a single done pulse.
- mul: a=7, b=9 → out=63, overflow=0.
- Reset at cycle 8 of a multiply → busy=0, no done pulse, out=0. A following add 2+3 returns 5 after 1 cycle.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/result bundle between a requester and alu_seq
interface alu_seq_if #(parameter int WIDTH = 16);
    logic             start;
    logic [3:0]       codop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             neg;
    logic             zero;
    logic             overflow;
    modport master (output start, codop, a, b, input busy, done, out, neg, zero, overflow);
    modport slave  (input start, codop, a, b, output busy, done, out, neg, zero, overflow);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/arith ops and a WIDTH-cycle shift-add multiply
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    typedef enum logic {IDLE, MUL} state_t;
    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     ma_q, ma_d, mb_q, mb_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;
    logic [SHW-1:0]       sh;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     res;
    logic                 res_ovf;
    logic [2*WIDTH-1:0]   acc_nx;
    always_comb begin
        sh      = bus.b[SHW-1:0];
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        res     = '0;
        res_ovf = 1'b0;
        case (bus.codop)
            4'd0, 4'd9:  begin res = sum[WIDTH-1:0]; res_ovf = sum[WIDTH]; end
            4'd1:        begin res = bus.b - bus.a; res_ovf = bus.a > bus.b; end
            4'd10:       begin res = bus.a - bus.b; res_ovf = bus.a < bus.b; end
            4'd2:        res = {{(WIDTH-1){1'b0}}, bus.a > bus.b};
            4'd3, 4'd6:  res = bus.a & bus.b;
            4'd4, 4'd7:  res = bus.a | bus.b;
            4'd5, 4'd8:  res = bus.a ^ bus.b;
            4'd11:       res = bus.a << sh;
            4'd12:       res = bus.a >> sh;
            4'd14:       res = $unsigned($signed(bus.a) >>> sh);
            default:     res = '0;
        endcase
        acc_nx  = acc_q + (mb_q[cnt_q] ? ({{WIDTH{1'b0}}, ma_q} << cnt_q) : '0);
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        out_d   = out_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (state_q == IDLE && bus.start && bus.codop == 4'd13) begin
            state_d = MUL;
            cnt_d   = '0;
            acc_d   = '0;
            ma_d    = bus.a;
            mb_d    = bus.b;
        end else if (state_q == IDLE && bus.start) begin
            out_d  = res;
            neg_d  = res[WIDTH-1];
            zero_d = res == '0;
            ovf_d  = res_ovf;
            done_d = 1'b1;
        end else if (state_q == MUL) begin
            acc_d = acc_nx;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH-1)) begin
                state_d = IDLE;
                out_d   = acc_nx[WIDTH-1:0];
                neg_d   = acc_nx[WIDTH-1];
                zero_d  = acc_nx[WIDTH-1:0] == '0;
                ovf_d   = |acc_nx[2*WIDTH-1:WIDTH];
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            out_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            out_q   <= out_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end
    assign bus.busy     = state_q == MUL;
    assign bus.done     = done_q;
    assign bus.out      = out_q;
    assign bus.neg      = neg_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq at WIDTH=16
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   dones;
    int   done_at;
    alu_seq_if #(.WIDTH(16)) bus ();
    alu_seq #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1;
        bus.codop = op;
        bus.a     = a;
        bus.b     = b;
        step();
    endtask
    initial begin
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.codop = 4'd0;
        bus.a = 16'd1;
        bus.b = 16'd1;
        step();
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_flags", {bus.neg, bus.zero, bus.overflow}, 0);
        rst_n = 1'b1;
        issue(4'd0, 16'hFFFF, 16'h0002);
        chk("add_out", bus.out, 16'h0001);
        chk("add_flags", {bus.neg, bus.zero, bus.overflow}, 3'b001);
        chk("add_done", bus.done, 1);
        issue(4'd1, 16'd5, 16'd5);
        chk("sub_out", bus.out, 0);
        chk("sub_flags", {bus.neg, bus.zero, bus.overflow}, 3'b010);
        bus.start = 1'b0;
        bus.a = 16'h1234;
        step();
        chk("idle_done", bus.done, 0);
        chk("idle_hold", {bus.out, bus.zero}, {16'h0, 1'b1});
        issue(4'd11, 16'h8001, 16'd4);
        chk("shl_out", {bus.done, bus.out}, {1'b1, 16'h0010});
        issue(4'd12, 16'h8001, 16'd4);
        chk("shr_out", {bus.done, bus.out}, {1'b1, 16'h0800});
        issue(4'd14, 16'h8001, 16'd4);
        chk("sra_out", {bus.done, bus.out, bus.neg}, {1'b1, 16'hF800, 1'b1});
        issue(4'd10, 16'd2, 16'd5);
        chk("subi", {bus.out, bus.overflow}, {16'hFFFD, 1'b1});
        issue(4'd2, 16'd3, 16'd2);
        chk("slti", {bus.out, bus.overflow}, {16'd1, 1'b0});
        issue(4'd8, 16'hF0F0, 16'hFF00);
        chk("xor", bus.out, 16'h0FF0);
        issue(4'd15, 16'h1111, 16'h2222);
        chk("op15", {bus.done, bus.out, bus.zero}, {1'b1, 16'h0, 1'b1});
        issue(4'd13, 16'd300, 16'd300);
        chk("mul_busy", {bus.busy, bus.done}, 2'b10);
        dones = 0;
        done_at = 0;
        for (int i = 1; i <= 20; i++) begin
            bus.start = (i == 5);
            bus.codop = 4'd0;
            bus.a = 16'd1;
            bus.b = 16'd1;
            step();
            if (bus.done) begin
                dones++;
                done_at = i;
            end
        end
        chk("mul_dones", dones, 1);
        chk("mul_lat", done_at, 16);
        chk("mul_out", {bus.out, bus.overflow, bus.busy}, {16'h5F90, 1'b1, 1'b0});
        issue(4'd13, 16'd7, 16'd9);
        bus.codop = 4'd0;
        bus.a = 16'd1;
        bus.b = 16'd1;
        done_at = 0;
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            step();
            if (bus.done) done_at = i;
        end
        chk("mul2_lat", done_at, 16);
        chk("mul2_out", {bus.out, bus.overflow}, {16'd63, 1'b0});
        step();
        chk("post_mul_add", {bus.done, bus.out}, {1'b1, 16'd2});
        issue(4'd13, 16'd300, 16'd300);
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        step();
        chk("abort", {bus.busy, bus.done, bus.out}, 0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done) dones++;
        end
        chk("abort_nodone", {dones[3:0], bus.out}, 0);
        issue(4'd0, 16'd2, 16'd3);
        chk("add_after", {bus.done, bus.out}, {1'b1, 16'd5});
        bus.start = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
